// File: rtl/infix_pkg.sv
// Shared token codes, token/state types and operator precedence
// for the infix-to-postfix converter.
package infix_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0100;
  localparam logic [3:0] OP_LPAR = 4'b1000;
  localparam logic [3:0] OP_RPAR = 4'b1001;

  typedef struct packed {
    logic       mode;
    logic [3:0] val;
  } tok_t;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    FLUSH,
    EMIT
  } state_t;

  // Parens rank 0 so they never get popped by an operator.
  function automatic logic [1:0] prec(input logic [3:0] c);
    case (c)
      OP_MUL:         return 2'd2;
      OP_ADD, OP_SUB: return 2'd1;
      default:        return 2'd0;
    endcase
  endfunction

  function automatic logic is_code(input logic [3:0] c);
    return c inside {OP_ADD, OP_SUB, OP_MUL, OP_LPAR, OP_RPAR};
  endfunction

endpackage

// File: rtl/infix2postfix_stack.sv
// op_stack: small LIFO of operator codes with synchronous reset.
// Pushes onto a full stack and pops from an empty one are ignored.
module op_stack #(
  parameter int W     = 4,
  parameter int DEPTH = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] top_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   SONE = (AW+1)'(1);
  localparam logic [AW-1:0] IONE = AW'(1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW:0]   sp_q;
  logic [AW-1:0] tidx;

  assign tidx    = sp_q[AW-1:0] - IONE;
  assign top_o   = mem_q[tidx];
  assign empty_o = (sp_q == '0);
  assign full_o  = (sp_q == FULL);

  always_ff @(posedge clk_i) begin
    if (push_i && !full_o)
      mem_q[sp_q[AW-1:0]] <= din_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      sp_q <= '0;
    else if (push_i && !full_o)
      sp_q <= sp_q + SONE;
    else if (pop_i && !empty_o)
      sp_q <= sp_q - SONE;
  end

endmodule

// File: rtl/infix2postfix.sv
// Shunting-yard infix-to-postfix converter: load, convert, emit burst.
// Define INFIX_ERR_CHECK_EN to flag malformed input on ERR.
module infix2postfix
  import infix_pkg::*;
#(
  parameter int DEPTH       = 32,
  parameter int STACK_DEPTH = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       IN_VALID,
  input  logic       OP_MODE,
  input  logic [3:0] IN,
  output logic       OUT_VALID,
  output logic       OUT_MODE,
  output logic [3:0] OUT,
  output logic       BUSY,
  output logic       ERR
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] MAXC = CW'(DEPTH);

  tok_t          tok_q [DEPTH];
  tok_t          pf_q  [DEPTH];
  logic [CW-1:0] cnt_q, rp_q, plen_q, ep_q;
  state_t        state_q;
  logic          skip_q, ov_q, om_q;
  logic [3:0]    o_q;

  tok_t       cur, pf_tok, in_tok;
  logic       load, push_req, st_push, st_pop;
  logic       emit_pf, adv, st_empty, st_full;
  logic [3:0] st_top;

`ifdef INFIX_ERR_CHECK_EN
  logic       flag_q, err_q, err_ev;
  logic [1:0] last_q, cls;
`endif

  assign in_tok = {OP_MODE, IN};
  assign load   = (state_q == IDLE) && IN_VALID && !skip_q
               && (!OP_MODE || is_code(IN));
  assign cur     = tok_q[rp_q[AW-1:0]];
  assign st_push = push_req && !st_full;

  always_comb begin
    push_req = 1'b0;
    st_pop   = 1'b0;
    emit_pf  = 1'b0;
    adv      = 1'b0;
    pf_tok   = cur;
    if (state_q == CONV) begin
      unique case (1'b1)
        !cur.mode: begin
          emit_pf = 1'b1;
          adv     = 1'b1;
        end
        cur.mode && cur.val == OP_LPAR: begin
          push_req = 1'b1;
          adv      = 1'b1;
        end
        cur.mode && cur.val == OP_RPAR: begin
          adv     = st_empty || st_top == OP_LPAR;
          st_pop  = !st_empty;
          emit_pf = !st_empty && st_top != OP_LPAR;
          pf_tok  = {1'b1, st_top};
        end
        default: begin
          if (!st_empty && prec(st_top) != 2'd0
              && prec(st_top) >= prec(cur.val)) begin
            st_pop  = 1'b1;
            emit_pf = 1'b1;
            pf_tok  = {1'b1, st_top};
          end else begin
            push_req = 1'b1;
            adv      = 1'b1;
          end
        end
      endcase
    end else if (state_q == FLUSH && !st_empty) begin
      st_pop  = 1'b1;
      emit_pf = st_top != OP_LPAR;
      pf_tok  = {1'b1, st_top};
    end
  end

  op_stack #(
    .W    (4),
    .DEPTH(STACK_DEPTH)
  ) u_stack (
    .clk_i  (CLK),
    .rst_i  (RESET),
    .push_i (st_push),
    .pop_i  (st_pop),
    .din_i  (cur.val),
    .top_o  (st_top),
    .empty_o(st_empty),
    .full_o (st_full)
  );

  always_ff @(posedge CLK) begin
    if (load && cnt_q < MAXC)
      tok_q[cnt_q[AW-1:0]] <= in_tok;
    if (emit_pf)
      pf_q[plen_q[AW-1:0]] <= pf_tok;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rp_q    <= '0;
      plen_q  <= '0;
      ep_q    <= '0;
      skip_q  <= 1'b0;
      ov_q    <= 1'b0;
      om_q    <= 1'b0;
      o_q     <= '0;
`ifdef INFIX_ERR_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
`ifdef INFIX_ERR_CHECK_EN
      err_q  <= 1'b0;
`endif
      // A burst that starts while busy stays ignored to its end.
      skip_q <= IN_VALID && (skip_q || state_q != IDLE);
      unique case (state_q)
        IDLE: begin
          if (load && cnt_q < MAXC) begin
            cnt_q <= cnt_q + ONE;
          end else if (!IN_VALID && cnt_q != '0) begin
            state_q <= CONV;
            rp_q    <= '0;
            plen_q  <= '0;
          end
        end
        CONV: begin
          if (emit_pf)
            plen_q <= plen_q + ONE;
          if (adv) begin
            rp_q <= rp_q + ONE;
            if (rp_q + ONE == cnt_q)
              state_q <= FLUSH;
          end
        end
        FLUSH: begin
          if (emit_pf)
            plen_q <= plen_q + ONE;
          if (st_empty) begin
`ifdef INFIX_ERR_CHECK_EN
            if (flag_q) begin
              err_q   <= 1'b1;
              state_q <= IDLE;
              cnt_q   <= '0;
              rp_q    <= '0;
              plen_q  <= '0;
            end else
`endif
            if (plen_q == '0) begin
              state_q <= IDLE;
              cnt_q   <= '0;
              rp_q    <= '0;
            end else begin
              state_q      <= EMIT;
              ov_q         <= 1'b1;
              {om_q, o_q}  <= pf_q[0];
              ep_q         <= ONE;
            end
          end
        end
        EMIT: begin
          if (ep_q == plen_q) begin
            state_q <= IDLE;
            ov_q    <= 1'b0;
            om_q    <= 1'b0;
            o_q     <= '0;
            cnt_q   <= '0;
            rp_q    <= '0;
            plen_q  <= '0;
            ep_q    <= '0;
          end else begin
            {om_q, o_q} <= pf_q[ep_q[AW-1:0]];
            ep_q        <= ep_q + ONE;
          end
        end
      endcase
    end
  end

`ifdef INFIX_ERR_CHECK_EN
  // Token class: 1 operand, 2 binary operator, 3 paren.
  always_comb begin
    cls = !OP_MODE ? 2'd1
        : (IN == OP_LPAR || IN == OP_RPAR) ? 2'd3 : 2'd2;
    err_ev = (push_req && st_full)
          || (state_q == CONV && cur.mode
              && cur.val == OP_RPAR && st_empty)
          || (state_q == FLUSH && !st_empty
              && st_top == OP_LPAR)
          || (load && (cnt_q == MAXC
              || (cnt_q != '0 && cls == last_q
                  && cls != 2'd3)));
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      flag_q <= 1'b0;
      last_q <= 2'd0;
    end else begin
      if (state_q == FLUSH && st_empty)
        flag_q <= 1'b0;
      else if (err_ev)
        flag_q <= 1'b1;
      if (load)
        last_q <= cls;
    end
  end

  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

  assign OUT_VALID = ov_q;
  assign OUT_MODE  = om_q;
  assign OUT       = o_q;
  assign BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_infix2postfix.sv
// Scoreboard bench for infix2postfix: directed expressions,
// ignored bursts while busy, and reset during emit.
module tb_infix2postfix;
  import infix_pkg::*;

  logic       CLK = 1'b0;
  logic       RESET, IN_VALID, OP_MODE;
  logic [3:0] IN;
  logic       OUT_VALID, OUT_MODE, BUSY, ERR;
  logic [3:0] OUT;

  int vec = 0;
  int bad = 0;
  int run = 0;
  int err_cnt = 0;
  int mlen;
  logic [4:0] mexp;
  logic [4:0] ex_q[$];
  int         len_q[$];

  localparam logic [4:0] ADD = {1'b1, OP_ADD};
  localparam logic [4:0] SUB = {1'b1, OP_SUB};
  localparam logic [4:0] MUL = {1'b1, OP_MUL};
  localparam logic [4:0] LP  = {1'b1, OP_LPAR};
  localparam logic [4:0] RP  = {1'b1, OP_RPAR};

  infix2postfix dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .IN_VALID (IN_VALID),
    .OP_MODE  (OP_MODE),
    .IN       (IN),
    .OUT_VALID(OUT_VALID),
    .OUT_MODE (OUT_MODE),
    .OUT      (OUT),
    .BUSY     (BUSY),
    .ERR      (ERR)
  );

  always #5 CLK = ~CLK;

  function automatic logic [4:0] N(input int v);
    return {1'b0, v[3:0]};
  endfunction

  always @(negedge CLK) begin
    if (ERR)
      err_cnt++;
    if (OUT_VALID) begin
      run++;
      vec++;
      if (ex_q.size() == 0) begin
        bad++;
        $display("FAIL extra_token got %b_%h want none",
                 OUT_MODE, OUT);
      end else begin
        mexp = ex_q.pop_front();
        if ({OUT_MODE, OUT} !== mexp) begin
          bad++;
          $display("FAIL token got %b_%h want %b_%h",
                   OUT_MODE, OUT, mexp[4], mexp[3:0]);
        end
      end
    end else if (run != 0) begin
      vec++;
      mlen = (len_q.size() != 0) ? len_q.pop_front() : 0;
      if (run != mlen) begin
        bad++;
        $display("FAIL burst_len got %0d want %0d", run, mlen);
      end
      run = 0;
    end
  end

  task automatic check(input string name,
                       input int got, input int want);
    vec++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic expect_out(input logic [4:0] t[$]);
    foreach (t[i]) ex_q.push_back(t[i]);
    len_q.push_back(t.size());
  endtask

  task automatic send(input logic [4:0] t[$]);
    foreach (t[i]) begin
      IN_VALID = 1'b1;
      {OP_MODE, IN} = t[i];
      @(negedge CLK);
    end
    IN_VALID = 1'b0;
    {OP_MODE, IN} = 5'd0;
  endtask

  task automatic wait_idle();
    @(negedge CLK);
    for (int i = 0; i < 300 && BUSY; i++)
      @(negedge CLK);
    check("busy_clear", int'(BUSY), 0);
    repeat (3) @(negedge CLK);
  endtask

  task automatic wait_ov();
    for (int i = 0; i < 300 && !OUT_VALID; i++)
      @(negedge CLK);
    check("out_valid_seen", int'(OUT_VALID), 1);
  endtask

  task automatic run_expr(input logic [4:0] i[$],
                          input logic [4:0] o[$]);
    expect_out(o);
    send(i);
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] iq[$];
    logic [4:0] oq[$];
    logic [4:0] i15[$];
    logic [4:0] o15[$];
    int e0;

    RESET = 1'b1;
    IN_VALID = 1'b0;
    OP_MODE = 1'b0;
    IN = 4'd0;
    repeat (3) @(negedge CLK);
    check("rst_out_valid", int'(OUT_VALID), 0);
    check("rst_out_mode", int'(OUT_MODE), 0);
    check("rst_out", int'(OUT), 0);
    check("rst_busy", int'(BUSY), 0);
    check("rst_err", int'(ERR), 0);
    RESET = 1'b0;
    @(negedge CLK);

    // 12+9*6
    iq = {N(12), ADD, N(9), MUL, N(6)};
    oq = {N(12), N(9), N(6), MUL, ADD};
    expect_out(oq);
    send(iq);
    @(negedge CLK);
    check("busy_in_conv", int'(BUSY), 1);
    wait_idle();

    i15 = {N(15), MUL, N(8), ADD, N(11), SUB, N(7), MUL,
           N(4), ADD, N(13), MUL, LP, N(12), MUL, N(11), RP};
    o15 = {N(15), N(8), MUL, N(11), ADD, N(7), N(4), MUL,
           SUB, N(13), N(12), N(11), MUL, MUL, ADD};
    run_expr(i15, o15);

    iq = {N(9), SUB, N(3), SUB, N(2)};
    oq = {N(9), N(3), SUB, N(2), SUB};
    run_expr(iq, oq);

    iq = {LP, N(1), ADD, N(2), RP, MUL, N(3)};
    oq = {N(1), N(2), ADD, N(3), MUL};
    run_expr(iq, oq);

    // Burst during EMIT must be dropped entirely.
    expect_out(o15);
    send(i15);
    wait_ov();
    iq = {N(1), ADD, N(2)};
    send(iq);
    wait_idle();
    repeat (10) @(negedge CLK);
    check("ignored_busy", int'(BUSY), 0);
    check("queue_drained", ex_q.size(), 0);

    // Reset after two emitted tokens aborts the burst.
    oq = {N(15), N(8)};
    expect_out(oq);
    send(i15);
    wait_ov();
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    check("rst_drop_valid", int'(OUT_VALID), 0);
    check("rst_drop_busy", int'(BUSY), 0);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    iq = {N(4), MUL, N(5)};
    oq = {N(4), N(5), MUL};
    run_expr(iq, oq);

`ifdef INFIX_ERR_CHECK_EN
    e0 = err_cnt;
    iq = {LP, N(3), ADD, N(4)};
    send(iq);
    wait_idle();
    check("err_lpar", err_cnt - e0, 1);

    e0 = err_cnt;
    iq = {};
    for (int k = 0; k < 33; k++)
      iq.push_back((k % 2 == 1) ? ADD : N(1));
    send(iq);
    wait_idle();
    check("err_overflow", err_cnt - e0, 1);
`else
    e0 = 0;
    check("err_tied_low", err_cnt, e0);
`endif

    repeat (3) @(negedge CLK);
    check("final_tokens_left", ex_q.size(), 0);
    check("final_bursts_left", len_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, bad);
    $finish;
  end

endmodule

// File: doc/infix2postfix.md
Name: infix2postfix

Overview:
- Upstream stage of the postfix evaluator; accepts an infix token stream and converts it with shunting-yard.
- Input tokens use the same encoding as the evaluator input: 4-bit operand, or operator flagged by a mode bit.
- Output is the equivalent postfix stream as one contiguous burst, ready to drive the evaluator's IN_VALID/OP_MODE/IN directly.
- Flow: buffer whole expression -> convert one action per cycle -> emit.

Parameters:
- DEPTH, 32, max tokens per infix expression; also the postfix buffer size.
- STACK_DEPTH, 16, operator/parenthesis stack entries.

Ports:
- CLK  in  1  clock, all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- IN_VALID  in  1  token valid; one expression = one contiguous high burst.
- OP_MODE  in  1  0 = IN is operand (0..15); 1 = IN is operator/paren code.
- IN  in  4  token value.
- OUT_VALID  out  1  postfix token valid; contiguous burst.
- OUT_MODE  out  1  0 = operand, 1 = operator; feeds evaluator OP_MODE.
- OUT  out  4  postfix token; feeds evaluator IN.
- BUSY  out  1  high in CONV/FLUSH/EMIT; input ignored while high.
- ERR  out  1  error pulse (see Optional Feature).

Behaviour:
- Operator codes (OP_MODE=1):
  - 4'b0001 '+', 4'b0010 '-', 4'b0100 '*', 4'b1000 '(', 4'b1001 ')'.
  - Any other code is dropped in LOAD (not stored).
- Precedence: '*'=2, '+'/'-'=1; all operators are left-associative. Parens never appear in the output.
- Reset: state=IDLE; all counters and pointers 0; OUT_VALID=0, OUT_MODE=0, OUT=0, BUSY=0, ERR=0.
- IDLE/LOAD:
  - Each IN_VALID=1 cycle writes {OP_MODE,IN} to the token buffer at cnt and increments cnt.
  - On the first IN_VALID=0 cycle with cnt>0, go to CONV. IDLE with cnt=0 stays IDLE.
- CONV: exactly one action per cycle on token[rp]:
  - Operand: append to postfix buffer; rp++.
  - '(': push; rp++.
  - ')': if stack top != '(', pop top to postfix and hold rp. Else pop and discard, rp++.
  - Operator o: if stack non-empty, top is an operator, and prec(top) >= prec(o), pop top to postfix and hold rp. Else push o, rp++.
  - rp==cnt: go to FLUSH.
- FLUSH:
  - Pop one entry per cycle to postfix; a leftover '(' is discarded.
  - Stack empty: go to EMIT.
- EMIT:
  - OUT_VALID=1 for exactly plen consecutive cycles, registered outputs, tokens in postfix order.
  - Then IDLE; cnt, rp and plen are cleared.
- Latency: first output token appears 1 cycle after CONV+FLUSH complete. CONV+FLUSH takes (infix token count + pops) cycles.
- BUSY:
  - BUSY=1 from CONV entry to the last EMIT cycle.
  - IN_VALID while BUSY: token discarded, no state change.
- Boundaries:
  - Token DEPTH+1 within one burst: discarded and the overflow flag is set.
  - Push onto a full stack: discarded and the overflow flag is set.
  - ')' on an empty stack: skipped; rp++.
- RESET mid-operation: abort immediately to IDLE; OUT_VALID drops the cycle after RESET is sampled.

Optional Feature:
- Macro: INFIX_ERR_CHECK_EN.
- Defined:
  - Overflow, unmatched ')', a '(' left in FLUSH, or two adjacent operands/operators in LOAD sets an error flag.
  - At end of FLUSH with the flag set: ERR pulses 1 cycle, EMIT is skipped (no OUT_VALID), return to IDLE.
- Undefined:
  - ERR tied 0.
  - Malformed input is converted best-effort per the rules above.

Decomposition:
- Package infix_pkg holds:
  - token codes OP_ADD, OP_SUB, OP_MUL, OP_LPAR, OP_RPAR;
  - a 5-bit token typedef {mode,val};
  - the state enum IDLE/CONV/FLUSH/EMIT;
  - the prec() function.
- One sub-module op_stack: parameterised LIFO with push/pop/top/empty/full and synchronous reset. The FSM and both buffers stay in the top module.

Test Plan:
- 12 + 9 * 6 -> OUT stream 12,9,6,*,+ with OUT_MODE 0,0,0,1,1, 5 contiguous OUT_VALID cycles. Feeding this to the evaluator yields 66.
- 15*8+11-7*4+13*(12*11) -> 15,8,*,11,+,7,4,*,-,13,12,11,*,*,+ (15 tokens). The evaluator yields 1819.
- 9-3-2 -> 9,3,-,2,- (left-associative); (1+2)*3 -> 1,2,+,3,*, with parens absent from the output.
- IN_VALID burst 1+2 issued while BUSY during a previous EMIT -> ignored; only the first expression is emitted; BUSY=0 afterwards.
- RESET=1 for one cycle during EMIT of the 15-token case -> OUT_VALID=0 the next cycle; a new expression 4*5 afterwards -> 4,5,*.
- INFIX_ERR_CHECK_EN defined, input (3+4 -> ERR=1 for one cycle, OUT_VALID never asserted. 33 tokens with DEPTH=32 -> ERR pulse.
